// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, 11 device-clocked bits, ACK check.
// Accepts one byte only in IDLE; further requests are ignored until tx_done, and a stalled device ends in timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drive_q, drive_d;
  logic          ack_ok_q, ack_ok_d;

  logic clk_s1, sync_clk, sync_clk_prev;
  logic data_s1, sync_data;
  logic fall;
  logic bus_idle;

  // Synchronisers reset to the released (high) bus level so reset never fakes a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1        <= 1'b1;
      sync_clk      <= 1'b1;
      sync_clk_prev <= 1'b1;
      data_s1       <= 1'b1;
      sync_data     <= 1'b1;
    end else begin
      clk_s1        <= ps2_clk_in;
      sync_clk      <= clk_s1;
      sync_clk_prev <= sync_clk;
      data_s1       <= ps2_data_in;
      sync_data     <= data_s1;
    end
  end

  assign fall     = sync_clk_prev & ~sync_clk;
  assign bus_idle = sync_clk & sync_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      drive_q  <= 1'b0;
      ack_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      drive_q  <= drive_d;
      ack_ok_q <= ack_ok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    cnt_d       = cnt_q;
    drive_d     = drive_q;
    ack_ok_d    = ack_ok_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_done     = 1'b0;
    tx_error    = 1'b0;

    // The watchdog restarts on every device clock fall while the device owns the clock.
    if (state_q inside {S_REQ, S_BITS, S_ACK, S_WAIT_IDLE}) begin
      cnt_d = fall ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d  = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = '0;
          cnt_d    = '0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REQ: begin
        ps2_data_oe = 1'b1;
        if (fall) begin
          drive_d  = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          bitcnt_d = 4'd1;
          state_d  = S_BITS;
        end
      end
      S_BITS: begin
        ps2_data_oe = drive_q;
        if (fall) begin
          drive_d  = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_ok_d = ~sync_data;
          state_d  = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (bus_idle) begin
          tx_done  = 1'b1;
          tx_error = ~ack_ok_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fall in the same cycle keeps the transfer alive; a completed handshake also wins.
    if ((state_q inside {S_REQ, S_BITS, S_ACK, S_WAIT_IDLE}) && (cnt_q == TO_LAST) && !fall
        && !(state_q == S_WAIT_IDLE && bus_idle)) begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      tx_done     = 1'b1;
      tx_error    = 1'b1;
      state_d     = S_IDLE;
    end
  end

  assign tx_ready = (state_q == S_IDLE);
  assign tx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain keyboard model clocks bytes out of the host.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 200;
  localparam int LO  = 8;
  localparam int HI  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  typedef struct {
    logic [7:0] data;
    logic       parity;
    logic       ack;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: waits for request-to-send, then clocks up to 11 falls and captures
  // each host bit just before the rising edge. rst_fall > 0 stops after that fall.
  task automatic dev_xfer(input logic ack, input int rst_fall, output logic [9:0] bits);
    int  n = 0;
    logic stop = 1'b0;
    bits = '0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("request_seen", 32'(n < 500), 32'd1);
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 11 && !stop; k++) begin
      dev_clk_low = 1'b1;
      if (k == rst_fall) begin
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stop = 1'b1;
      end else begin
        repeat (LO) @(negedge clk);
        if (k <= 10) bits[k-1] = ps2_data_in;
        dev_clk_low = 1'b0;
        if (k == 11) dev_data_low = 1'b0;
        if (k == 10 && ack) begin
          repeat (2) @(negedge clk);
          dev_data_low = 1'b1;
          repeat (HI - 2) @(negedge clk);
        end else if (k < 11) begin
          repeat (HI) @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_done(output logic seen, output logic err, output logic rdy);
    int n = 0;
    while (!tx_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    seen = tx_done;
    err  = tx_error;
    rdy  = tx_ready;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [9:0] bits;
    logic seen, err, rdy;
    send(v.data);
    dev_xfer(v.ack, 0, bits);
    wait_done(seen, err, rdy);
    check({tag, "_bits"}, 32'(bits), 32'({1'b1, v.parity, v.data}));
    check({tag, "_odd_parity"}, 32'(^bits[8:0]), 32'd1);
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_error"}, 32'(err), 32'(v.exp_err));
    check({tag, "_ready_at_done"}, 32'(rdy), 32'd0);
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    logic [9:0] bits;
    logic seen, err, rdy;
    int n, m, dones;

    vecs[0] = '{data: 8'hED, parity: 1'b1, ack: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'h01, parity: 1'b0, ack: 1'b1, exp_err: 1'b0};
    vecs[2] = '{data: 8'h00, parity: 1'b1, ack: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 8'hA5, parity: 1'b1, ack: 1'b0, exp_err: 1'b1};
    vecs[4] = '{data: 8'h80, parity: 1'b0, ack: 1'b1, exp_err: 1'b0};

    rst = 1'b1;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    check("reset_error", 32'(tx_error), 32'd0);
    check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("reset_data_oe", 32'(ps2_data_oe), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Silent device: inhibit length, then watchdog expiry.
    send(8'h12);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", 32'(n), 32'(INH));
    m = 1;
    while (!tx_done && m < 1000) begin
      @(negedge clk);
      m++;
    end
    check("timeout_cycles", 32'(m), 32'(TO));
    check("timeout_error", 32'(tx_error), 32'd1);
    check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    check("timeout_ready_after", 32'(tx_ready), 32'd1);

    // Reset at fall 5 of the data phase.
    send(8'h3C);
    dev_xfer(1'b1, 5, bits);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_mid_data_oe", 32'(ps2_data_oe), 32'd0);
    dev_clk_low = 1'b0;
    dones = 0;
    repeat (30) begin
      if (tx_done) dones++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 32'(dones), 32'd0);
    run_vec("after_rst_ff", '{data: 8'hFF, parity: 1'b1, ack: 1'b1, exp_err: 1'b0});

    // A second request during a transfer is dropped and tx_data changes are ignored.
    send(8'hF4);
    tx_data = 8'h55;
    repeat (5) @(negedge clk);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_xfer(1'b1, 0, bits);
    wait_done(seen, err, rdy);
    check("busy_drop_bits", 32'(bits), 32'({1'b1, 1'b0, 8'hF4}));
    check("busy_drop_done", 32'(seen), 32'd1);
    check("busy_drop_error", 32'(err), 32'd0);
    repeat (10) @(negedge clk);
    check("busy_drop_no_restart", 32'({tx_ready, ps2_clk_oe}), 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
